// File: rtl/axis_pkt_gen.sv
// AXI4-Stream test packet generator: runs of framed packets with a programmable
// inter-packet gap and one of four data patterns.
module axis_pkt_gen #(
  parameter int BEAT_SIZE  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cfg_start,
  input  logic                            cfg_abort,
  input  logic [LEN_WIDTH-1:0]            cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0]            cfg_pkt_num,
  input  logic [GAP_WIDTH-1:0]            cfg_gap,
  input  logic [1:0]                      cfg_mode,
  input  logic [DATA_WIDTH-1:0]           cfg_fill,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_WIDTH-1:0]            pkt_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]            state_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beat_reg;
  logic [CNT_WIDTH-1:0]  num_reg;
  logic [CNT_WIDTH-1:0]  sent_reg;
  logic [GAP_WIDTH-1:0]  gap_reg;
  logic [GAP_WIDTH-1:0]  gap_cnt_reg;
  logic [1:0]            mode_reg;
  logic [DATA_WIDTH-1:0] fill_reg;
  logic                  abort_pend_reg;
  logic                  done_reg;

  logic send;
  logic last_beat;
  logic start_ok;
  logic run_end;

  assign send      = (state_reg == SEND);
  assign last_beat = (beat_reg == len_reg - LEN_WIDTH'(1));
  assign start_ok  = cfg_start && !cfg_abort && (cfg_pkt_len != '0) && (cfg_pkt_num != '0);
  // An abort arriving on the tlast beat itself still ends the run at this boundary.
  assign run_end   = (sent_reg + CNT_WIDTH'(1) == num_reg) || abort_pend_reg || cfg_abort;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      beat_reg       <= '0;
      num_reg        <= '0;
      sent_reg       <= '0;
      gap_reg        <= '0;
      gap_cnt_reg    <= '0;
      mode_reg       <= '0;
      fill_reg       <= '0;
      abort_pend_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            len_reg        <= cfg_pkt_len;
            num_reg        <= cfg_pkt_num;
            gap_reg        <= cfg_gap;
            mode_reg       <= cfg_mode;
            fill_reg       <= cfg_fill;
            sent_reg       <= '0;
            beat_reg       <= '0;
            abort_pend_reg <= 1'b0;
            state_reg      <= SEND;
          end
        end
        SEND: begin
          if (cfg_abort) begin
            abort_pend_reg <= 1'b1;
          end
          if (m_axis_tready) begin
            if (last_beat) begin
              sent_reg <= sent_reg + CNT_WIDTH'(1);
              beat_reg <= '0;
              if (run_end) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end else if (gap_reg != '0) begin
                state_reg   <= GAP;
                gap_cnt_reg <= '0;
              end
            end else begin
              beat_reg <= beat_reg + LEN_WIDTH'(1);
            end
          end
        end
        GAP: begin
          // Counts 0..gap inclusive: gap idle cycles plus the cycle back into SEND.
          if (cfg_abort || abort_pend_reg) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else if (gap_cnt_reg == gap_reg) begin
            state_reg <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_WIDTH'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] beat_d;
  logic [DATA_WIDTH-1:0] pkt_d;

  // The completed-packet count doubles as the index of the packet being sent.
  assign beat_d = DATA_WIDTH'(beat_reg);
  assign pkt_d  = DATA_WIDTH'(sent_reg);

  for (genvar gi = 0; gi < BEAT_SIZE; gi++) begin : g_sample
    logic [DATA_WIDTH-1:0] sample;
    always_comb begin
      case (mode_reg)
        2'd0:    sample = fill_reg;
        2'd1:    sample = fill_reg + beat_d;
        2'd2:    sample = fill_reg + beat_d * DATA_WIDTH'(BEAT_SIZE) + DATA_WIDTH'(gi);
        default: sample = fill_reg + pkt_d;
      endcase
    end
    assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = send ? sample : '0;
  end

  assign m_axis_tvalid = send;
  assign m_axis_tlast  = send && last_beat;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign pkt_sent      = sent_reg;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Randomized bench for axis_pkt_gen; expected streams come from the packet/pattern
// rules directly, one print line per run.
module tb_axis_pkt_gen;

  logic         aclk;
  logic         aresetn;
  logic         cfg_start;
  logic         cfg_abort;
  logic [15:0]  cfg_pkt_len;
  logic [15:0]  cfg_pkt_num;
  logic [15:0]  cfg_gap;
  logic [1:0]   cfg_mode;
  logic [15:0]  cfg_fill;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         busy;
  logic         done;
  logic [15:0]  pkt_sent;

  int n_checks = 0;
  int n_fail   = 0;

  axis_pkt_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_pkt_num   (cfg_pkt_num),
    .cfg_gap       (cfg_gap),
    .cfg_mode      (cfg_mode),
    .cfg_fill      (cfg_fill),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .pkt_sent      (pkt_sent)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_beat(input int mode, input logic [15:0] fill,
                                            input int b, input int p);
    logic [127:0] v;
    logic [15:0]  s;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       s = fill;
        1:       s = fill + 16'(b);
        2:       s = fill + 16'(b * 8 + k);
        default: s = fill + 16'(p);
      endcase
      v[k*16 +: 16] = s;
    end
    return v;
  endfunction

  // abort_phase: 0 none, 1 pulse while a beat is presented, 2 pulse during an idle gap;
  // pulsed on the first qualifying cycle once abort_hs beats have been accepted.
  task automatic run(input int mode, input logic [15:0] fill, input int len, input int num,
                     input int gap, input int rdy_pct, input int abort_phase, input int abort_hs);
    logic [127:0] exp_q[$];
    bit           last_q[$];
    int           hs, exp_total, idle, cycles, n;
    bit           after_last, end_check, stall_prev, aborted;
    logic [127:0] prev_data;
    logic         prev_last;
    for (int p = 0; p < num; p++)
      for (int b = 0; b < len; b++) begin
        exp_q.push_back(exp_beat(mode, fill, b, p));
        last_q.push_back(b == len - 1);
      end
    exp_total = num * len;
    hs = 0; idle = 0; cycles = 0;
    after_last = 0; end_check = 0; stall_prev = 0; aborted = 0;
    prev_data = '0; prev_last = 0;

    @(negedge aclk);
    cfg_mode = 2'(mode); cfg_fill = fill; cfg_pkt_len = 16'(len);
    cfg_pkt_num = 16'(num); cfg_gap = 16'(gap); cfg_start = 1; cfg_abort = 0;
    @(negedge aclk);
    check("first_valid", 128'(m_axis_tvalid), 128'd1);

    while (!end_check && cycles < 20000) begin
      // Scramble cfg inputs and pulse start while busy: both must be ignored.
      cfg_start     = ($urandom_range(99) < 10);
      cfg_pkt_len   = 16'($urandom);
      cfg_pkt_num   = 16'($urandom);
      cfg_gap       = 16'($urandom);
      cfg_mode      = 2'($urandom);
      cfg_fill      = 16'($urandom);
      cfg_abort     = 0;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      check("done_early", 128'(done), 128'd0);
      check("busy_run", 128'(busy), 128'd1);
      if (stall_prev) begin
        check("hold_valid", 128'(m_axis_tvalid), 128'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 128'(m_axis_tlast), 128'(prev_last));
      end
      if (abort_phase != 0 && !aborted && hs >= abort_hs &&
          m_axis_tvalid == (abort_phase == 1)) begin
        cfg_abort = 1;
        aborted   = 1;
        n = (abort_phase == 1) ? hs / len + 1 : hs / len;
        if (n > num) n = num;
        exp_total = n * len;
        if (abort_phase == 2) end_check = 1;
      end
      if (m_axis_tvalid) begin
        if (after_last) begin
          check("gap_len", 128'(idle), 128'((gap == 0) ? 0 : gap + 1));
          after_last = 0;
        end
        if (m_axis_tready) begin
          if (hs >= exp_total) begin
            check("extra_beat", 128'(hs), 128'(exp_total));
            end_check = 1;
          end else begin
            check($sformatf("data%0d", hs), m_axis_tdata, exp_q[hs]);
            check($sformatf("last%0d", hs), 128'(m_axis_tlast), 128'(last_q[hs]));
            hs++;
            if (hs == exp_total) end_check = 1;
          end
          if (m_axis_tlast) begin
            after_last = 1;
            idle = 0;
          end
        end
      end else if (after_last) begin
        idle++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      cycles++;
      @(negedge aclk);
    end
    cfg_start = 0;
    cfg_abort = 0;
    if (!end_check) begin
      check("timeout", 128'd0, 128'd1);
    end else begin
      check("done_pulse", 128'(done), 128'd1);
      check("busy_end", 128'(busy), 128'd0);
      check("valid_end", 128'(m_axis_tvalid), 128'd0);
      check("pkt_sent", 128'(pkt_sent), 128'(exp_total / len));
      @(negedge aclk);
      check("done_width", 128'(done), 128'd0);
    end
    $display("run mode=%0d fill=%h len=%0d num=%0d gap=%0d rdy=%0d abort=%0d beats=%0d",
             mode, fill, len, num, gap, rdy_pct, abort_phase, hs);
  endtask

  task automatic bad_start(input string tag, input int len, input int num, input bit abort);
    @(negedge aclk);
    cfg_pkt_len = 16'(len); cfg_pkt_num = 16'(num); cfg_gap = 0; cfg_mode = 0;
    cfg_start = 1; cfg_abort = abort;
    @(negedge aclk);
    cfg_start = 0; cfg_abort = 0;
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_valid"}, 128'(m_axis_tvalid), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    @(negedge aclk);
    check({tag, "_done2"}, 128'(done), 128'd0);
    $display("start ignored case %s len=%0d num=%0d abort=%0d", tag, len, num, abort);
  endtask

  initial begin
    int hs, cyc;
    aclk = 0; aresetn = 0; cfg_start = 0; cfg_abort = 0; cfg_pkt_len = 0;
    cfg_pkt_num = 0; cfg_gap = 0; cfg_mode = 0; cfg_fill = 0; m_axis_tready = 0;
    repeat (3) @(negedge aclk);
    check("rst_valid", 128'(m_axis_tvalid), 128'd0);
    check("rst_last", 128'(m_axis_tlast), 128'd0);
    check("rst_data", m_axis_tdata, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_sent", 128'(pkt_sent), 128'd0);
    aresetn = 1;

    run(0, 16'hFFFF, 128, 1, 0, 100, 0, 0);
    run(2, 16'h0000, 4, 2, 3, 100, 0, 0);
    run(1, 16'h0000, 16, 1, 0, 50, 0, 0);
    run(3, 16'hFFFF, 2, 3, 0, 100, 0, 0);
    run(1, 16'($urandom), 32, 10, 2, 70, 1, 5);
    run(2, 16'($urandom), 4, 5, 3, 80, 2, 4);
    for (int i = 0; i < 10; i++) begin
      int len, num, gap, ph;
      len = $urandom_range(1, 6);
      num = $urandom_range(1, 4);
      gap = $urandom_range(0, 3);
      ph  = $urandom_range(0, 2);
      if (ph == 2 && gap == 0) ph = 1;
      run($urandom_range(0, 3), 16'($urandom), len, num, gap, $urandom_range(30, 100),
          ph, $urandom_range(0, len * num));
    end

    // Reset in the middle of a run.
    @(negedge aclk);
    cfg_mode = 1; cfg_fill = 16'h1234; cfg_pkt_len = 4; cfg_pkt_num = 8; cfg_gap = 1;
    cfg_start = 1; m_axis_tready = 1;
    @(negedge aclk);
    cfg_start = 0;
    hs = 0; cyc = 0;
    while (hs < 10 && cyc < 200) begin
      if (m_axis_tvalid && m_axis_tready) hs++;
      cyc++;
      @(negedge aclk);
    end
    if (hs < 10) check("rst_timeout", 128'd0, 128'd1);
    check("pre_rst_sent", 128'(pkt_sent), 128'd2);
    aresetn = 0;
    @(negedge aclk);
    aresetn = 1;
    check("mid_rst_valid", 128'(m_axis_tvalid), 128'd0);
    check("mid_rst_last", 128'(m_axis_tlast), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_sent", 128'(pkt_sent), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    @(negedge aclk);
    check("post_rst_busy", 128'(busy), 128'd0);
    check("post_rst_done", 128'(done), 128'd0);
    $display("reset mid-run after %0d beats", hs);

    bad_start("len0", 0, 3, 0);
    bad_start("num0", 4, 0, 0);
    bad_start("abort", 4, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
